fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN, meaning PC width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ValidF, input, 1, meaning the fetch stage presents an instruction.
REQ-006 SHALL have port InstrF, input, 32, the fetched instruction.
REQ-007 SHALL have port PCF, input, XLEN, the PC of InstrF.
REQ-008 SHALL have port PCPlus4F, input, XLEN, PCF+4.
REQ-009 SHALL have port ReadyF, output, 1, meaning the queue accepts; fetch drives StallF = ~ReadyF.
REQ-010 SHALL have port FlushD, input, 1, meaning discard all entries (driven by PCSrcE).
REQ-011 SHALL have port ReadyD, input, 1, meaning decode consumes the head this cycle.
REQ-012 SHALL have port ValidD, output, 1, meaning the head entry is valid.
REQ-013 SHALL have port InstrD, output, 32, the head instruction.
REQ-014 SHALL have port PCD, output, XLEN, the head PC.
REQ-015 SHALL have port PCPlus4D, output, XLEN, the head PC+4.
REQ-016 SHALL have port Count, output, $clog2(DEPTH)+1, the current occupancy.

Function
REQ-017 SHALL push {InstrF,PCF,PCPlus4F} on a rising edge when ValidF && ReadyF && !FlushD.
REQ-018 SHALL pop the head on a rising edge when ValidD && ReadyD && !FlushD.
REQ-019 SHALL drive ReadyF = (Count != DEPTH), combinational from registered state only; no dependence on ReadyD or any pass-through when full.
REQ-020 SHALL drive ValidD = (Count != 0), from registered state only.
REQ-021 SHALL present the entry pushed at edge N on the outputs after edge N when the queue was empty: one-cycle latency, no combinational input-to-output bypass.
REQ-022 SHALL, while ValidD=0, drive InstrD=riscv_pkg::NOP_INSTR (32'h00000013), PCD=0, PCPlus4D=0.
REQ-023 SHALL deliver entries in strict FIFO order.
REQ-024 SHALL, on a simultaneous push and pop, perform both and leave Count unchanged.
REQ-025 SHALL, when FlushD=1 at an edge, set Count=0 and both pointers to 0, and ignore any concurrent push or pop; flush has priority.
REQ-026 SHALL wrap read and write pointers modulo DEPTH, using natural log2(DEPTH)-bit overflow.
REQ-027 SHALL ignore ValidF when ReadyF=0: no overwrite, no pointer change.
REQ-028 SHALL never let Count exceed DEPTH or go below 0.

Reset
REQ-029 SHALL, on rst asserted asynchronously, immediately force Count=0, pointers=0, ValidD=0, ReadyF=1, and InstrD=NOP.
REQ-030 SHALL leave storage array contents unreset; outputs are still defined per REQ-022.
REQ-031 SHALL accept a push on the first rising edge after rst deasserts.
REQ-032 SHALL, if rst asserts mid-operation, lose all queued entries with no partial pop.

Structure
REQ-033 SHALL take XLEN and the constant NOP_INSTR from riscv_pkg; NOP_INSTR is added there if absent.
REQ-034 SHALL be a single module with inline storage and no sub-module; an optional SIM-guarded $strobe trace matches the fetch stage format.

Verification
REQ-035 Reset then push 0x00500093 at PC 0x0: the next cycle gives ValidD=1, InstrD=0x00500093, PCD=0x0, PCPlus4D=0x4, Count=1.
REQ-036 ReadyD=0 with 4 pushes at PCs 0x0,0x4,0x8,0xC: Count=4 and ReadyF=0; a 5th ValidF is dropped; ReadyD=1 drains 0x0,0x4,0x8,0xC in order.
REQ-037 Steady ValidF=ReadyD=1 for 10 cycles: Count holds at 1 and PCD increments by 4 each cycle across pointer wrap.
REQ-038 Count=3 with FlushD=1 and concurrent ValidF/ReadyD: the next cycle gives Count=0, ValidD=0, InstrD=0x00000013; the pushed entry is absent.
REQ-039 Count=2 with rst pulsed between clock edges: outputs go immediately to Count=0, ValidD=0, ReadyF=1.
REQ-040 Full queue with simultaneous ReadyD=1 and ValidF=1: the pop occurs, the push is rejected, and Count=3.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Fetch queue local types.
// fq_op_e: per-edge queue operation, encoded as {push,pop}.
package fetch_queue_pkg;
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fq_op_e;
endpackage

// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the pipeline.
// XLEN: register/PC width; NOP_INSTR: canonical addi x0,x0,0.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch->decode queue bundle with both handshakes.
// master: fetch/decode side; slave: the queue itself.
interface fetch_queue_if #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 4
);
  logic                     ValidF;
  logic [31:0]              InstrF;
  logic [XLEN-1:0]          PCF;
  logic [XLEN-1:0]          PCPlus4F;
  logic                     ReadyF;
  logic                     FlushD;
  logic                     ReadyD;
  logic                     ValidD;
  logic [31:0]              InstrD;
  logic [XLEN-1:0]          PCD;
  logic [XLEN-1:0]          PCPlus4D;
  logic [$clog2(DEPTH):0]   Count;

  modport master (
    output ValidF, InstrF, PCF, PCPlus4F,
    output FlushD, ReadyD,
    input  ReadyF, ValidD, InstrD,
    input  PCD, PCPlus4D, Count
  );

  modport slave (
    input  ValidF, InstrF, PCF, PCPlus4F,
    input  FlushD, ReadyD,
    output ReadyF, ValidD, InstrD,
    output PCD, PCPlus4D, Count
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode.
// Ports: clk/rst, fetch push side (ValidF/ReadyF + payload),
// decode pop side (ValidD/ReadyD + payload), FlushD, Count.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ValidF,
  input  logic [31:0]            InstrF,
  input  logic [XLEN-1:0]        PCF,
  input  logic [XLEN-1:0]        PCPlus4F,
  output logic                   ReadyF,
  input  logic                   FlushD,
  input  logic                   ReadyD,
  output logic                   ValidD,
  output logic [31:0]            InstrD,
  output logic [XLEN-1:0]        PCD,
  output logic [XLEN-1:0]        PCPlus4D,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [AW-1:0] STEP = AW'(1);

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc4_q   [DEPTH];

  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;

  logic   push;
  logic   pop;
  fq_op_e op;

  // Handshakes look only at registered occupancy, so a full
  // queue never relies on a same-cycle pop to accept.
  assign ReadyF = (cnt_q != FULL);
  assign ValidD = (cnt_q != '0);
  assign Count  = cnt_q;

  assign push = ValidF && ReadyF && !FlushD;
  assign pop  = ValidD && ReadyD && !FlushD;
  assign op   = fq_op_e'({push, pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (FlushD) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      unique case (op)
        OP_IDLE: ;
        OP_POP: begin
          rp_q  <= rp_q + STEP;
          cnt_q <= cnt_q - ONE;
        end
        OP_PUSH: begin
          wp_q  <= wp_q + STEP;
          cnt_q <= cnt_q + ONE;
        end
        OP_BOTH: begin
          wp_q <= wp_q + STEP;
          rp_q <= rp_q + STEP;
        end
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; empty outputs are masked.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wp_q] <= InstrF;
      pc_q[wp_q]    <= PCF;
      pc4_q[wp_q]   <= PCPlus4F;
    end
  end

  assign InstrD   = ValidD ? instr_q[rp_q] : riscv_pkg::NOP_INSTR;
  assign PCD      = ValidD ? pc_q[rp_q]    : '0;
  assign PCPlus4D = ValidD ? pc4_q[rp_q]   : '0;

endmodule
